multi_mole_round: RTL



---
 rtl/whack_pkg.sv | 23 ++
 rtl/lsfr.sv | 17 +
 rtl/mole_slot.sv | 57 +++++
 rtl/multi_mole_round.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole round logic.
// State encoding plus a saturating counter increment.
package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam int MAX_CNT_W = 32;

    // Increment v, holding at 2^w-1 for a w-bit counter.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] v,
        input int unsigned          w
    );
        logic [MAX_CNT_W:0] lim;
        lim = ((MAX_CNT_W+1)'(1) << w) - (MAX_CNT_W+1)'(1);
        return ({1'b0, v} >= lim) ? v : v + MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/lsfr.sv
// Free-running 8-bit maximal-length LFSR used as the mole position source.
// Polynomial x^8+x^6+x^5+x^4+1, seeded non-zero on reset.
module lsfr (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= 8'h01;
        end else begin
            out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
        end
    end

endmodule

// File: rtl/mole_slot.sv
// One mole slot: occupied flag, hole index and a down-counting lifetime.
// A kill in the same cycle as the final tick wins over the expiry.
module mole_slot #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spawn_i,
    input  logic [IDX_W-1:0] spawn_idx_i,
    input  logic [CNT_W-1:0] spawn_dur_i,
    input  logic             kill_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             expire_o
);

    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             last;

    assign last     = (tmr_q == CNT_W'(1));
    assign valid_o  = valid_q;
    assign idx_o    = idx_q;
    assign expire_o = valid_q & last & ~kill_i;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        if (!valid_q) begin
            if (spawn_i) begin
                valid_d = 1'b1;
                idx_d   = spawn_idx_i;
                tmr_d   = spawn_dur_i;
            end
        end else if (kill_i || last) begin
            valid_d = 1'b0;
        end else begin
            tmr_d = tmr_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            tmr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
        end
    end

endmodule

// File: rtl/multi_mole_round.sv
// Round controller with several simultaneous moles, hit edge detection
// and per-round score / escape / wrong-hit counters.
module multi_mole_round
    import whack_pkg::*;
#(
    parameter  int NUM_HOLES = 16,
    parameter  int MAX_MOLES = 2,
    parameter  int CNT_W     = 27,
    parameter  int COUNT_W   = 8,
    localparam int IDX_W     = $clog2(NUM_HOLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 round_start,
    input  logic [CNT_W-1:0]     interval,
    input  logic [CNT_W-1:0]     duration,
    input  logic [COUNT_W-1:0]   molenum,
    input  logic                 hit,
    input  logic [IDX_W-1:0]     hit_index,
    output logic [NUM_HOLES-1:0] mole_mask,
    output logic                 round_over,
    output logic                 round_done,
    output logic                 hit_success,
    output logic                 wrong_hit,
    output logic                 escape,
    output logic [COUNT_W-1:0]   score,
    output logic [COUNT_W-1:0]   escapes,
    output logic [COUNT_W-1:0]   wrong_hits
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     interval_q, interval_d;
    logic [CNT_W-1:0]     duration_q, duration_d;
    logic [COUNT_W-1:0]   molenum_q, molenum_d;
    logic [COUNT_W-1:0]   spawned_q, spawned_d;
    logic [CNT_W-1:0]     icnt_q, icnt_d;
    logic [COUNT_W-1:0]   score_q, score_d;
    logic [COUNT_W-1:0]   escapes_q, escapes_d;
    logic [COUNT_W-1:0]   wrong_q, wrong_d;
    logic                 hit_q;
    logic                 succ_q, succ_d;
    logic                 whit_q, whit_d;
    logic                 esc_q, esc_d;

    logic [7:0]           rnd;
    logic [IDX_W-1:0]     cand;
    logic                 run, hit_edge, hit_good;
    logic                 dup, cand_ok, spawn_ok, found;
    logic [CNT_W-1:0]     dur_eff;
    logic [MAX_MOLES-1:0] slot_valid, slot_expire;
    logic [MAX_MOLES-1:0] slot_spawn, slot_kill, free_sel;
    logic [IDX_W-1:0]     slot_idx [MAX_MOLES];

    lsfr u_lsfr (
        .clk (clk),
        .rst (rst),
        .out (rnd)
    );

    assign cand    = IDX_W'(rnd);
    assign run     = (state_q == ST_RUN);
    assign dur_eff = (duration_q == '0) ? CNT_W'(1) : duration_q;

    for (genvar g = 0; g < MAX_MOLES; g++) begin : g_slot
        mole_slot #(
            .IDX_W (IDX_W),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .spawn_i     (slot_spawn[g]),
            .spawn_idx_i (cand),
            .spawn_dur_i (dur_eff),
            .kill_i      (slot_kill[g]),
            .valid_o     (slot_valid[g]),
            .idx_o       (slot_idx[g]),
            .expire_o    (slot_expire[g])
        );
    end

    // Duplicate check and hit lookup both use the pre-update slot state.
    always_comb begin
        mole_mask = '0;
        dup       = 1'b0;
        slot_kill = '0;
        free_sel  = '0;
        found     = 1'b0;
        hit_edge  = run & hit & ~hit_q;
        for (int s = 0; s < MAX_MOLES; s++) begin
            if (slot_valid[s]) begin
                mole_mask[slot_idx[s]] = 1'b1;
                if (slot_idx[s] == cand) dup = 1'b1;
                if (hit_edge && slot_idx[s] == hit_index) begin
                    slot_kill[s] = 1'b1;
                end
            end else if (!found) begin
                free_sel[s] = 1'b1;
                found       = 1'b1;
            end
        end
        hit_good   = |slot_kill;
        cand_ok    = ({1'b0, cand} < (IDX_W+1)'(NUM_HOLES)) & ~dup;
        spawn_ok   = run & (icnt_q == interval_q) & (spawned_q < molenum_q)
                   & found & cand_ok;
        slot_spawn = spawn_ok ? free_sel : '0;
    end

    always_comb begin
        state_d    = state_q;
        interval_d = interval_q;
        duration_d = duration_q;
        molenum_d  = molenum_q;
        spawned_d  = spawned_q;
        icnt_d     = icnt_q;
        score_d    = score_q;
        escapes_d  = escapes_q;
        wrong_d    = wrong_q;
        succ_d     = 1'b0;
        whit_d     = 1'b0;
        esc_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (round_start) begin
                    state_d    = ST_RUN;
                    interval_d = interval;
                    duration_d = duration;
                    molenum_d  = molenum;
                    spawned_d  = '0;
                    icnt_d     = interval;
                    score_d    = '0;
                    escapes_d  = '0;
                    wrong_d    = '0;
                end
            end
            ST_RUN: begin
                if (spawn_ok) begin
                    icnt_d    = '0;
                    spawned_d = spawned_q + COUNT_W'(1);
                end else if (icnt_q != interval_q) begin
                    icnt_d = icnt_q + CNT_W'(1);
                end
                if (hit_edge) begin
                    if (hit_good) begin
                        score_d = COUNT_W'(sat_inc(MAX_CNT_W'(score_q), COUNT_W));
                        succ_d  = 1'b1;
                    end else begin
                        wrong_d = COUNT_W'(sat_inc(MAX_CNT_W'(wrong_q), COUNT_W));
                        whit_d  = 1'b1;
                    end
                end
                for (int s = 0; s < MAX_MOLES; s++) begin
                    if (slot_expire[s]) begin
                        escapes_d = COUNT_W'(sat_inc(MAX_CNT_W'(escapes_d), COUNT_W));
                    end
                end
                esc_d = |slot_expire;
                if (spawned_q == molenum_q && slot_valid == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            interval_q <= '0;
            duration_q <= '0;
            molenum_q  <= '0;
            spawned_q  <= '0;
            icnt_q     <= '0;
            score_q    <= '0;
            escapes_q  <= '0;
            wrong_q    <= '0;
            hit_q      <= 1'b0;
            succ_q     <= 1'b0;
            whit_q     <= 1'b0;
            esc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            duration_q <= duration_d;
            molenum_q  <= molenum_d;
            spawned_q  <= spawned_d;
            icnt_q     <= icnt_d;
            score_q    <= score_d;
            escapes_q  <= escapes_d;
            wrong_q    <= wrong_d;
            hit_q      <= hit;
            succ_q     <= succ_d;
            whit_q     <= whit_d;
            esc_q      <= esc_d;
        end
    end

    assign round_over  = (state_q == ST_IDLE);
    assign round_done  = (state_q == ST_DONE);
    assign hit_success = succ_q;
    assign wrong_hit   = whit_q;
    assign escape      = esc_q;
    assign score       = score_q;
    assign escapes     = escapes_q;
    assign wrong_hits  = wrong_q;

endmodule
